dmasnd_fifo: RTL and testbench
==============================

# dmasnd_fifo

Parametrised DMA-sound sample buffer sitting between the GSTMCU sound DMA (SREQ/SLOAD_N handshake) and the audio output path of the shifter. Accepts 16-bit words fetched from RAM, holds them in a DEPTH-word FIFO, and plays them out as 8-bit signed samples on a sample-rate strobe in stereo or mono mode. It requests refills with a configurable slack margin, and reports underrun and overrun.

## Interface
- DEPTH, 4: FIFO depth in 16-bit words; power of 2, ≥2.
- MARGIN, 1: free slots kept in reserve for an in-flight DMA word; 0 ≤ MARGIN < DEPTH.
- LW, $clog2(DEPTH+1): width of `level`.
- clk32  in  1  system clock; all logic on the rising edge.
- resb  in  1  reset, asynchronous, active-low.
- enable  in  1  DMA playback on; low flushes and idles the block.
- mono  in  1  1 = mono (two samples per word), 0 = stereo (hi=left, lo=right).
- sload_n  in  1  word strobe from MCU; a high→low transition captures `mdin`.
- mdin  in  16  RAM data word.
- sample_tick  in  1  one-cycle strobe at sample rate.
- sreq  out  1  refill request to MCU.
- audio_left  out  8  signed left sample.
- audio_right  out  8  signed right sample.
- level  out  LW  words currently in the FIFO.
- underrun  out  1  sticky; pop required while empty.
- overrun  out  1  one-cycle pulse; word strobed while full and not popped.

## Operation
- Reset (resb low, async): FIFO pointers and level 0; phase 0; sreq, audio_left, audio_right, underrun, overrun all 0.
- Write: `sload_n` is registered. A write occurs in the cycle where the registered value is 1 and the current value is 0, so a low pulse of any length counts once. The write is accepted if `level < DEPTH`, or if `level == DEPTH` and a pop happens in the same cycle. Otherwise the word is dropped and `overrun` pulses.
- Pop on `sample_tick` with enable high:
  - Stereo: pop one word; audio_left = word[15:8], audio_right = word[7:0]; phase stays 0.
  - Mono, phase 0: pop a word into the hold register; both outputs = word[15:8]; phase → 1.
  - Mono, phase 1: both outputs = hold[7:0]; phase → 0; no pop.
- Empty when a pop is required: outputs hold their previous values, phase unchanged, `underrun` set. No write-through: a word written in the same cycle is not visible to that pop.
- Mode change: `mono` is sampled at each tick. Stereo selected while phase = 1 forces phase 0 and pops normally.
- sreq = enable & (level + MARGIN < DEPTH), registered.
- enable low: pointers, level and phase cleared every cycle; outputs 0; sreq 0; writes ignored; overrun 0. `underrun` is cleared on the enable 0→1 transition.
- Simultaneous write and pop: `level` unchanged; read and write pointers each advance, modulo DEPTH.

## Timing
- Write latency: capture edge is the first clk32 edge where the registered sload_n is 1 and sload_n is 0. Word is poppable from the next edge; `level` updates at the capture edge.
- Audio latency: outputs change at the clock edge that samples `sample_tick` high, so they are visible the cycle after the tick.
- sreq: one cycle after a `level`/enable change, because it is registered from post-update state.
- overrun: high for exactly the cycle after the dropped-strobe edge.
- Back-to-back sample_tick on consecutive cycles is legal. Each tick is processed fully.
- Async reset mid-transfer: all state is cleared immediately. The first falling sload_n after release is captured only if the registered sload_n was 1, and its reset value is 1.

## Structure
- Package `dmasnd_pkg`: phase encoding constants (PH_HI, PH_LO) and sample/word width localparams (SW = 8, WW = 16).
- Sub-module `snd_sync_fifo` (params DEPTH, WW): register-array FIFO with push/pop/flush, `level`, and full/empty flags. Top level holds the edge detector, mode/phase FSM, output registers and flags.

## Test plan
- Stereo: DEPTH = 4, enable; strobe 0x7F80, 0x0102; two ticks → (L,R) = (0x7F,0x80), then (0x01,0x02); level 2→0; sreq high once level + 1 < 4.
- Mono: strobe 0xA55A; ticks → both outputs 0xA5, then 0x5A; level drops to 0 at the first tick only.
- Underrun: enable with an empty FIFO, tick → outputs stay 0, underrun = 1; toggle enable 0→1 → underrun = 0.
- Overrun: fill 4 words, fifth strobe with no tick → overrun pulses one cycle, level = 4. Fifth strobe coincident with a tick → accepted, level stays 4.
- Long sload_n low of 5 cycles → exactly one write.
- Reset mid-stream: assert resb low with level 3 → level, sreq and audio are 0 asynchronously. After release, a stereo tick with no writes → underrun.

Source files
------------

// File: rtl/dmasnd_fifo_pkg.sv
// Shared widths and phase encoding for the DMA-sound sample buffer.
package dmasnd_pkg;

  localparam int SW = 8;
  localparam int WW = 16;

  // PH_HI: next tick plays a fresh word's high byte; PH_LO: next tick plays the held low byte.
  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_e;

endpackage

// File: rtl/snd_sync_fifo.sv
// Register-array FIFO with a synchronous flush and an occupancy count.
// A push into a full FIFO is legal only when a pop retires a word in the same cycle.
module snd_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WW    = 16,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [WW-1:0] wdata_i,
  output logic [WW-1:0] rdata_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [WW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dmasnd_fifo.sv
// DMA-sound sample buffer: captures words on falling sload_n, plays them out as
// stereo or mono 8-bit samples on sample_tick, and requests refills via sreq.
module dmasnd_fifo
  import dmasnd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int MARGIN = 1,
  parameter int LW     = $clog2(DEPTH + 1)
) (
  input  logic          clk32,
  input  logic          resb,
  input  logic          enable,
  input  logic          mono,
  input  logic          sload_n,
  input  logic [WW-1:0] mdin,
  input  logic          sample_tick,
  output logic          sreq,
  output logic [SW-1:0] audio_left,
  output logic [SW-1:0] audio_right,
  output logic [LW-1:0] level,
  output logic          underrun,
  output logic          overrun
);

  logic          sload_q;
  logic          enable_q;
  phase_e        phase_q, phase_d;
  logic [SW-1:0] left_q, left_d;
  logic [SW-1:0] right_q, right_d;
  logic [SW-1:0] hold_q, hold_d;
  logic          und_q, und_d;
  logic          ovr_q, ovr_d;
  logic          sreq_q, sreq_d;

  logic [WW-1:0] fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          wr_strobe;
  logic          pop;
  logic          push;
  logic          und_evt;

  // A low pulse of any length yields a single strobe on its leading edge.
  assign wr_strobe = sload_q & ~sload_n;
  assign push      = enable & wr_strobe & (~fifo_full | pop);

  snd_sync_fifo #(
    .DEPTH (DEPTH),
    .WW    (WW)
  ) u_fifo (
    .clk_i   (clk32),
    .rst_ni  (resb),
    .flush_i (~enable),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (mdin),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Phase/output next-state: a tick either replays the held low byte (mono second
  // half) or consumes a word; an empty FIFO leaves everything as it was.
  always_comb begin
    phase_d = phase_q;
    left_d  = left_q;
    right_d = right_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    und_evt = 1'b0;
    if (!enable) begin
      phase_d = PH_HI;
      left_d  = '0;
      right_d = '0;
      hold_d  = '0;
    end else if (sample_tick) begin
      if (mono && (phase_q == PH_LO)) begin
        left_d  = hold_q;
        right_d = hold_q;
        phase_d = PH_HI;
      end else if (fifo_empty) begin
        und_evt = 1'b1;
      end else begin
        pop    = 1'b1;
        left_d = fifo_rdata[15:8];
        if (mono) begin
          right_d = fifo_rdata[15:8];
          hold_d  = fifo_rdata[7:0];
          phase_d = PH_LO;
        end else begin
          right_d = fifo_rdata[7:0];
          phase_d = PH_HI;
        end
      end
    end
  end

  always_comb begin
    ovr_d  = enable & wr_strobe & fifo_full & ~pop;
    und_d  = ((enable & ~enable_q) ? 1'b0 : und_q) | und_evt;
    sreq_d = enable & (({1'b0, fifo_level} + (LW + 1)'(MARGIN)) < (LW + 1)'(DEPTH));
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      phase_q <= PH_HI;
    end else begin
      phase_q <= phase_d;
    end
  end

  // sload_q resets high so a line already low at release is not taken as a strobe.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      sload_q  <= 1'b1;
      enable_q <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
      hold_q   <= '0;
      und_q    <= 1'b0;
      ovr_q    <= 1'b0;
      sreq_q   <= 1'b0;
    end else begin
      sload_q  <= sload_n;
      enable_q <= enable;
      left_q   <= left_d;
      right_q  <= right_d;
      hold_q   <= hold_d;
      und_q    <= und_d;
      ovr_q    <= ovr_d;
      sreq_q   <= sreq_d;
    end
  end

  assign sreq        = sreq_q;
  assign audio_left  = left_q;
  assign audio_right = right_q;
  assign level       = fifo_level;
  assign underrun    = und_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_dmasnd_fifo.sv
// Bench for dmasnd_fifo: directed scenarios plus a random phase, every cycle
// compared against a queue-based model of the sample buffer.
module tb_dmasnd_fifo;

  localparam int DEPTH  = 4;
  localparam int MARGIN = 1;
  localparam int LW     = $clog2(DEPTH + 1);

  // clock / reset
  logic clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  logic          resb;
  logic          enable;
  logic          mono;
  logic          sload_n;
  logic [15:0]   mdin;
  logic          sample_tick;
  logic          sreq;
  logic [7:0]    audio_left;
  logic [7:0]    audio_right;
  logic [LW-1:0] level;
  logic          underrun;
  logic          overrun;

  dmasnd_fifo #(
    .DEPTH  (DEPTH),
    .MARGIN (MARGIN),
    .LW     (LW)
  ) dut (
    .clk32       (clk32),
    .resb        (resb),
    .enable      (enable),
    .mono        (mono),
    .sload_n     (sload_n),
    .mdin        (mdin),
    .sample_tick (sample_tick),
    .sreq        (sreq),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .level       (level),
    .underrun    (underrun),
    .overrun     (overrun)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard / reference model
  logic [15:0] exp_q[$];
  bit          m_sload_prev;
  bit          m_en_prev;
  bit          m_phase;
  bit          m_und;
  bit          m_ovr;
  bit          m_sreq;
  logic [7:0]  m_left;
  logic [7:0]  m_right;
  logic [7:0]  m_hold;

  task automatic model_reset();
    exp_q.delete();
    m_sload_prev = 1'b1;
    m_en_prev    = 1'b0;
    m_phase      = 1'b0;
    m_und        = 1'b0;
    m_ovr        = 1'b0;
    m_sreq       = 1'b0;
    m_left       = '0;
    m_right      = '0;
    m_hold       = '0;
  endtask

  // One clock edge of the buffer's behaviour, using the inputs present at that edge.
  task automatic model_update();
    automatic bit          strobe = m_sload_prev && !sload_n;
    automatic int          lvl    = exp_q.size();
    automatic bit          popped = 1'b0;
    automatic logic [15:0] w;
    m_sreq = enable && ((lvl + MARGIN) < DEPTH);
    if (!enable) begin
      exp_q.delete();
      m_phase = 1'b0;
      m_left  = '0;
      m_right = '0;
      m_hold  = '0;
      m_ovr   = 1'b0;
    end else begin
      if (!m_en_prev) m_und = 1'b0;
      if (sample_tick) begin
        if (mono && m_phase) begin
          m_left  = m_hold;
          m_right = m_hold;
          m_phase = 1'b0;
        end else if (lvl == 0) begin
          m_und = 1'b1;
        end else begin
          w      = exp_q.pop_front();
          popped = 1'b1;
          m_left = w[15:8];
          if (mono) begin
            m_right = w[15:8];
            m_hold  = w[7:0];
            m_phase = 1'b1;
          end else begin
            m_right = w[7:0];
            m_phase = 1'b0;
          end
        end
      end
      m_ovr = 1'b0;
      if (strobe) begin
        if (lvl < DEPTH || popped) exp_q.push_back(mdin);
        else m_ovr = 1'b1;
      end
    end
    m_sload_prev = sload_n;
    m_en_prev    = enable;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, 16'(level), 16'(exp_q.size()));
    chk({tag, ".sreq"}, 16'(sreq), 16'(m_sreq));
    chk({tag, ".left"}, 16'(audio_left), 16'(m_left));
    chk({tag, ".right"}, 16'(audio_right), 16'(m_right));
    chk({tag, ".underrun"}, 16'(underrun), 16'(m_und));
    chk({tag, ".overrun"}, 16'(overrun), 16'(m_ovr));
  endtask

  // driver tasks: inputs change at the falling edge, outputs sampled at the next one
  task automatic cycle(input string tag);
    @(posedge clk32);
    model_update();
    @(negedge clk32);
    check_all(tag);
  endtask

  task automatic strobe_word(input logic [15:0] w);
    sload_n = 1'b0;
    mdin    = w;
    cycle("wr");
    sload_n = 1'b1;
    cycle("wr_idle");
  endtask

  task automatic tick_once(input string tag);
    sample_tick = 1'b1;
    cycle(tag);
    sample_tick = 1'b0;
  endtask

  initial begin
    resb        = 1'b0;
    enable      = 1'b0;
    mono        = 1'b0;
    sload_n     = 1'b1;
    mdin        = '0;
    sample_tick = 1'b0;
    model_reset();

    // reset values
    repeat (2) @(negedge clk32);
    check_all("reset");
    resb = 1'b1;
    cycle("idle");

    enable = 1'b1;
    cycle("en");
    chk("sreq_empty", 16'(sreq), 16'h1);

    // stereo
    strobe_word(16'h7F80);
    strobe_word(16'h0102);
    chk("st_level2", 16'(level), 16'h2);
    tick_once("st_t0");
    chk("st_l0", 16'(audio_left), 16'h7F);
    chk("st_r0", 16'(audio_right), 16'h80);
    tick_once("st_t1");
    chk("st_l1", 16'(audio_left), 16'h01);
    chk("st_r1", 16'(audio_right), 16'h02);
    chk("st_level0", 16'(level), 16'h0);

    // mono
    mono = 1'b1;
    strobe_word(16'hA55A);
    tick_once("mo_t0");
    chk("mo_hi", {audio_left, audio_right}, 16'hA5A5);
    chk("mo_level", 16'(level), 16'h0);
    tick_once("mo_t1");
    chk("mo_lo", {audio_left, audio_right}, 16'h5A5A);

    // underrun and its clear on enable rising
    mono = 1'b0;
    tick_once("ur_tick");
    chk("ur_set", 16'(underrun), 16'h1);
    chk("ur_hold", {audio_left, audio_right}, 16'h5A5A);
    enable = 1'b0;
    cycle("ur_off0");
    cycle("ur_off1");
    chk("ur_sticky", 16'(underrun), 16'h1);
    enable = 1'b1;
    cycle("ur_on");
    chk("ur_clr", 16'(underrun), 16'h0);

    // overrun
    for (int i = 0; i < DEPTH; i++) strobe_word(16'h1000 + 16'(i * 16'h0101));
    chk("ov_full", 16'(level), 16'(DEPTH));
    chk("ov_sreq", 16'(sreq), 16'h0);
    sload_n = 1'b0;
    mdin    = 16'hDEAD;
    cycle("ov_drop");
    chk("ov_pulse", 16'(overrun), 16'h1);
    chk("ov_level", 16'(level), 16'(DEPTH));
    sload_n = 1'b1;
    cycle("ov_after");
    chk("ov_once", 16'(overrun), 16'h0);
    sload_n     = 1'b0;
    mdin        = 16'hCAFE;
    sample_tick = 1'b1;
    cycle("ov_pop");
    chk("ov_pop_lvl", 16'(level), 16'(DEPTH));
    chk("ov_pop_ovr", 16'(overrun), 16'h0);
    sload_n     = 1'b1;
    sample_tick = 1'b0;
    cycle("ov_pop_idle");

    // back-to-back ticks drain, then one long low pulse
    sample_tick = 1'b1;
    repeat (DEPTH) cycle("drain");
    sample_tick = 1'b0;
    chk("drain_empty", 16'(level), 16'h0);
    sload_n = 1'b0;
    mdin    = 16'h1234;
    repeat (5) cycle("long_low");
    sload_n = 1'b1;
    cycle("long_rel");
    chk("long_one", 16'(level), 16'h1);

    // mono -> stereo mid-pair forces a fresh pop
    mono = 1'b1;
    strobe_word(16'hBEEF);
    tick_once("mc_mono");
    chk("mc_mono", {audio_left, audio_right}, 16'h1212);
    mono = 1'b0;
    tick_once("mc_st");
    chk("mc_stereo", {audio_left, audio_right}, 16'hBEEF);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      sload_n     = ($urandom_range(0, 3) != 0);
      mdin        = 16'($urandom);
      sample_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) mono = ~mono;
      enable      = ($urandom_range(0, 39) != 0);
      cycle("rand");
    end

    // async reset mid-stream
    sload_n     = 1'b1;
    sample_tick = 1'b0;
    mono        = 1'b0;
    enable      = 1'b0;
    cycle("pre_rst_off");
    enable = 1'b1;
    cycle("pre_rst_on");
    for (int i = 0; i < DEPTH; i++) strobe_word(16'h8100 + 16'(i));
    tick_once("pre_rst_tick");
    chk("pre_rst_lvl", 16'(level), 16'h3);
    #1 resb = 1'b0;
    #1;
    model_reset();
    chk("rst_level", 16'(level), 16'h0);
    chk("rst_sreq", 16'(sreq), 16'h0);
    chk("rst_audio", {audio_left, audio_right}, 16'h0);
    repeat (2) @(negedge clk32);
    resb = 1'b1;
    tick_once("post_rst_tick");
    chk("post_rst_und", 16'(underrun), 16'h1);
    cycle("post_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
